// File: rtl/wb_stage_pkg.sv
// Shared encodings for the writeback stage: writeback select, load funct3 codes
// and the control bundle held in the MEM/WB pipeline register.
package wb_stage_pkg;

  typedef enum logic [1:0] {
    WBSEL_ALU  = 2'b00,
    WBSEL_LOAD = 2'b01,
    WBSEL_PC4  = 2'b10,
    WBSEL_IMM  = 2'b11
  } wbsel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Control half of the MEM/WB register; the data word is kept separately
  // because its width is a module parameter.
  typedef struct packed {
    logic       valid;
    logic       fresh;
    logic       regwrite;
    logic       exc;
    logic [4:0] rd;
  } wb_ctrl_t;

  localparam wb_ctrl_t WB_CTRL_RESET = '{valid: 1'b0, fresh: 1'b0, regwrite: 1'b0,
                                         exc: 1'b0, rd: REG_ZERO};

endpackage

// File: rtl/wb_stage_if.sv
// MEM-to-WB bundle plus the register-file write port, forwarding and status
// outputs of the writeback stage.
interface wb_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) ();

  logic                  mem_valid;
  logic                  mem_regwrite;
  logic [4:0]            mem_rd;
  logic [1:0]            mem_wbsel;
  logic [2:0]            mem_funct3;
  logic [1:0]            mem_addr_lo;
  logic [DATA_WIDTH-1:0] mem_alu_result;
  logic [DATA_WIDTH-1:0] mem_load_data;
  logic [DATA_WIDTH-1:0] mem_pc4;
  logic [DATA_WIDTH-1:0] mem_imm;
  logic                  stall;
  logic                  flush;

  logic                  rf_we;
  logic [4:0]            rf_rd;
  logic [DATA_WIDTH-1:0] rf_wd;
  logic                  fwd_valid;
  logic [4:0]            fwd_rd;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic                  wb_exc;
  logic [CNT_WIDTH-1:0]  retire_cnt;

  // The pipeline (MEM stage and hazard unit) drives the master side.
  modport master (
    output mem_valid, mem_regwrite, mem_rd, mem_wbsel, mem_funct3, mem_addr_lo,
           mem_alu_result, mem_load_data, mem_pc4, mem_imm, stall, flush,
    input  rf_we, rf_rd, rf_wd, fwd_valid, fwd_rd, fwd_data, wb_exc, retire_cnt
  );

  modport slave (
    input  mem_valid, mem_regwrite, mem_rd, mem_wbsel, mem_funct3, mem_addr_lo,
           mem_alu_result, mem_load_data, mem_pc4, mem_imm, stall, flush,
    output rf_we, rf_rd, rf_wd, fwd_valid, fwd_rd, fwd_data, wb_exc, retire_cnt
  );

endinterface

// File: rtl/wb_stage_load_align.sv
// Load lane extraction with sign/zero extension and misalignment detection.
// Purely combinational; the caller decides whether the instruction is a load.
module load_align
  import wb_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  bad
);

  logic [DATA_WIDTH-1:0] byte_shift;
  logic [DATA_WIDTH-1:0] half_shift;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;

  assign byte_shift = word >> {addr_lo, 3'b000};
  assign half_shift = word >> {addr_lo[1], 4'b0000};
  assign lane_b     = byte_shift[7:0];
  assign lane_h     = half_shift[15:0];

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    data = '0;
    bad  = 1'b0;
    case (funct3)
      F3_LB:  data = {{(DATA_WIDTH-8){lane_b[7]}}, lane_b};
      F3_LBU: data = {{(DATA_WIDTH-8){1'b0}}, lane_b};
      F3_LH: begin
        data = {{(DATA_WIDTH-16){lane_h[15]}}, lane_h};
        bad  = addr_lo[0];
      end
      F3_LHU: begin
        data = {{(DATA_WIDTH-16){1'b0}}, lane_h};
        bad  = addr_lo[0];
      end
      F3_LW: begin
        data = word;
        bad  = (addr_lo != 2'b00);
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, writeback mux, register-file write
// port (one write per instruction), forwarding, load exception and retire count.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input logic     clk,
  input logic     rst,
  wb_stage_if.slave bus
);

  wbsel_e                wbsel;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_bad;
  logic [DATA_WIDTH-1:0] wd_d;
  logic                  exc_d;

  wb_ctrl_t              ctrl_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  fwd_ok;
  logic                  retire;

  assign wbsel = wbsel_e'(bus.mem_wbsel);

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .funct3  (bus.mem_funct3),
    .addr_lo (bus.mem_addr_lo),
    .word    (bus.mem_load_data),
    .data    (load_data),
    .bad     (load_bad)
  );

  // Writeback value is selected before the register so rf_wd leaves a flop.
  always_comb begin
    wd_d  = bus.mem_alu_result;
    exc_d = 1'b0;
    case (wbsel)
      WBSEL_ALU:  wd_d = bus.mem_alu_result;
      WBSEL_LOAD: begin
        wd_d  = load_data;
        exc_d = load_bad;
      end
      WBSEL_PC4:  wd_d = bus.mem_pc4;
      WBSEL_IMM:  wd_d = bus.mem_imm;
      default:    wd_d = bus.mem_alu_result;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= WB_CTRL_RESET;
      wd_q   <= '0;
    end else if (bus.flush) begin
      ctrl_q.valid <= 1'b0;
      ctrl_q.fresh <= 1'b0;
    end else if (bus.stall) begin
      // Entry stays visible for forwarding but must not write or retire again.
      ctrl_q.fresh <= 1'b0;
    end else begin
      ctrl_q.valid    <= bus.mem_valid;
      ctrl_q.fresh    <= bus.mem_valid;
      ctrl_q.regwrite <= bus.mem_regwrite;
      ctrl_q.exc      <= exc_d;
      ctrl_q.rd       <= bus.mem_rd;
      wd_q            <= wd_d;
    end
  end

  assign retire = ctrl_q.valid & ctrl_q.fresh & ~ctrl_q.exc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (retire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign fwd_ok = ctrl_q.valid & ctrl_q.regwrite & (ctrl_q.rd != REG_ZERO) & ~ctrl_q.exc;

  assign bus.rf_we      = fwd_ok & ctrl_q.fresh;
  assign bus.rf_rd      = ctrl_q.rd;
  assign bus.rf_wd      = wd_q;
  assign bus.fwd_valid  = fwd_ok;
  assign bus.fwd_rd     = ctrl_q.rd;
  assign bus.fwd_data   = wd_q;
  assign bus.wb_exc     = ctrl_q.valid & ctrl_q.fresh & ctrl_q.exc;
  assign bus.retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases plus random traffic checked
// against an instruction-level model of the writeback stage.
module tb_wb_stage;

  localparam int DW = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_stage_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  wb_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model: the instruction sitting in writeback and whether its one-time
  // effects (write, exception, retire) are still owed.
  typedef struct {
    bit        valid;
    bit        owed;
    bit        regw;
    bit        exc;
    bit [4:0]  rd;
    bit [31:0] wd;
  } slot_t;

  slot_t slot;
  int    retired;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [31:0] ref_wd(bit [1:0] sel, bit [2:0] f3, bit [1:0] a,
                                       bit [31:0] alu, bit [31:0] ld,
                                       bit [31:0] pc4, bit [31:0] imm);
    longint v;
    if (sel == 2'd0) return alu;
    if (sel == 2'd2) return pc4;
    if (sel == 2'd3) return imm;
    case (f3)
      3'd0: begin v = (ld >> (8 * a)) & 255;        if (v >= 128)   v -= 256;   end
      3'd1: begin v = (ld >> (16 * (a / 2))) & 65535; if (v >= 32768) v -= 65536; end
      3'd2: v = ld;
      3'd4: v = (ld >> (8 * a)) & 255;
      3'd5: v = (ld >> (16 * (a / 2))) & 65535;
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  function automatic bit ref_exc(bit [1:0] sel, bit [2:0] f3, bit [1:0] a);
    if (sel != 2'd1) return 1'b0;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
    if (f3 == 3'd2 && a != 2'd0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    slot    = '{valid: 0, owed: 0, regw: 0, exc: 0, rd: 0, wd: 0};
    retired = 0;
  endtask

  task automatic model_edge();
    if (slot.valid && slot.owed && !slot.exc) retired++;
    if (bus.flush) begin
      slot.valid = 0;
      slot.owed  = 0;
    end else if (bus.stall) begin
      slot.owed = 0;
    end else begin
      slot.valid = bus.mem_valid;
      slot.owed  = bus.mem_valid;
      slot.regw  = bus.mem_regwrite;
      slot.rd    = bus.mem_rd;
      slot.exc   = ref_exc(bus.mem_wbsel, bus.mem_funct3, bus.mem_addr_lo);
      slot.wd    = ref_wd(bus.mem_wbsel, bus.mem_funct3, bus.mem_addr_lo, bus.mem_alu_result,
                          bus.mem_load_data, bus.mem_pc4, bus.mem_imm);
    end
  endtask

  task automatic compare_all();
    bit writes, fwd;
    fwd    = slot.valid && slot.regw && slot.rd != 0 && !slot.exc;
    writes = fwd && slot.owed;
    check("rf_we", bus.rf_we, writes);
    check("rf_rd", bus.rf_rd, slot.rd);
    if (!slot.exc) check("rf_wd", bus.rf_wd, slot.wd);
    check("fwd_valid", bus.fwd_valid, fwd);
    check("fwd_rd", bus.fwd_rd, slot.rd);
    if (fwd) check("fwd_data", bus.fwd_data, slot.wd);
    check("wb_exc", bus.wb_exc, slot.valid && slot.owed && slot.exc);
    check("retire_cnt", bus.retire_cnt, retired % (1 << CW));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_op(input bit v, input bit rw, input bit [4:0] rd, input bit [1:0] sel,
                        input bit [2:0] f3, input bit [1:0] a, input bit [31:0] val);
    bus.mem_valid      = v;
    bus.mem_regwrite   = rw;
    bus.mem_rd         = rd;
    bus.mem_wbsel      = sel;
    bus.mem_funct3     = f3;
    bus.mem_addr_lo    = a;
    bus.mem_alu_result = val;
    bus.mem_load_data  = val;
    bus.mem_pc4        = val + 4;
    bus.mem_imm        = val ^ 32'hFFFF_0000;
    bus.stall          = 1'b0;
    bus.flush          = 1'b0;
  endtask

  initial begin
    model_reset();
    set_op(0, 0, 0, 0, 0, 0, 0);
    #12;
    check("rst_rf_we", bus.rf_we, 0);
    check("rst_rf_wd", bus.rf_wd, 0);
    check("rst_fwd_valid", bus.fwd_valid, 0);
    check("rst_wb_exc", bus.wb_exc, 0);
    check("rst_retire", bus.retire_cnt, 0);
    rst = 1'b0;

    // ALU write to x5
    set_op(1, 1, 5'd5, 2'b00, 0, 0, 32'h1234);
    step();
    check("alu_we", bus.rf_we, 1);
    check("alu_rd", bus.rf_rd, 5);
    check("alu_wd", bus.rf_wd, 32'h0000_1234);
    set_op(0, 0, 0, 0, 0, 0, 0);
    step();
    check("alu_retire", bus.retire_cnt, 1);

    // Load extension on 0x80FF7F01
    set_op(1, 1, 5'd9, 2'b01, 3'b000, 2'd1, 32'h80FF_7F01);
    step(); check("lb_a1", bus.rf_wd, 32'h0000_007F);
    set_op(1, 1, 5'd9, 2'b01, 3'b000, 2'd3, 32'h80FF_7F01);
    step(); check("lb_a3", bus.rf_wd, 32'hFFFF_FF80);
    set_op(1, 1, 5'd9, 2'b01, 3'b101, 2'd2, 32'h80FF_7F01);
    step(); check("lhu_a2", bus.rf_wd, 32'h0000_80FF);
    set_op(1, 1, 5'd9, 2'b01, 3'b001, 2'd2, 32'h80FF_7F01);
    step(); check("lh_a2", bus.rf_wd, 32'hFFFF_80FF);

    // Misaligned LW: one-shot exception, no write, no retire
    set_op(1, 1, 5'd7, 2'b01, 3'b010, 2'd2, 32'h1111_2222);
    step();
    check("mis_exc", bus.wb_exc, 1);
    check("mis_we", bus.rf_we, 0);
    check("mis_fwd", bus.fwd_valid, 0);
    set_op(0, 0, 0, 0, 0, 0, 0);
    step();
    check("mis_exc_once", bus.wb_exc, 0);

    // Stall hold: a single write, forwarding for all held cycles
    set_op(1, 1, 5'd3, 2'b00, 0, 0, 32'hA);
    step();
    check("hold_we0", bus.rf_we, 1);
    bus.stall = 1'b1;
    bus.mem_rd = 5'd12;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_we", bus.rf_we, 0);
      check("hold_fwd", bus.fwd_valid, 1);
      check("hold_fwd_data", bus.fwd_data, 32'hA);
    end

    // flush beats stall
    set_op(1, 1, 5'd4, 2'b00, 0, 0, 32'h55);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    step();
    check("flush_we", bus.rf_we, 0);
    check("flush_fwd", bus.fwd_valid, 0);

    // rd = x0 still retires
    set_op(1, 1, 5'd0, 2'b00, 0, 0, 32'h77);
    step();
    check("x0_we", bus.rf_we, 0);
    check("x0_fwd", bus.fwd_valid, 0);
    set_op(0, 0, 0, 0, 0, 0, 0);
    step();

    // Async reset while a write is pending
    set_op(1, 1, 5'd8, 2'b10, 0, 0, 32'h100);
    step();
    check("pre_rst_we", bus.rf_we, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_we", bus.rf_we, 0);
    check("arst_fwd", bus.fwd_valid, 0);
    check("arst_retire", bus.retire_cnt, 0);
    model_reset();
    rst = 1'b0;

    // Counter wraps after 16 retires with a 4-bit counter
    for (int i = 1; i <= 17; i++) begin
      set_op(1, 1, 5'(i), 2'b11, 0, 0, 32'(i));
      step();
    end
    check("wrap", bus.retire_cnt, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_op($urandom_range(0, 3) != 0, $urandom_range(0, 1), 5'($urandom_range(0, 31)),
             2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             $urandom);
      bus.mem_load_data = $urandom;
      bus.stall = ($urandom_range(0, 4) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 5-stage core: the write-side driver of the integer register file.
- Latches MEM-stage results into the MEM/WB pipeline register on posedge clk and selects the writeback value (ALU, load, PC+4, immediate).
- Aligns and sign/zero-extends load data, then drives the register file's write port, which commits on the negedge of the same cycle.
- Also exports forwarding data, a one-shot load-misalignment exception and a retired-instruction counter.

Parameters:
- DATA_WIDTH, 32, datapath width.
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset: asynchronous, active-high.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_regwrite  in  1  instruction writes rd.
- mem_rd  in  5  destination register.
- mem_wbsel  in  2  writeback select: 00 ALU, 01 load, 10 PC+4, 11 immediate.
- mem_funct3  in  3  load size/sign.
- mem_addr_lo  in  2  effective address bits [1:0].
- mem_alu_result  in  DATA_WIDTH  ALU result.
- mem_load_data  in  DATA_WIDTH  raw aligned word from data memory.
- mem_pc4  in  DATA_WIDTH  PC+4.
- mem_imm  in  DATA_WIDTH  U-type immediate.
- stall  in  1  hold the MEM/WB register.
- flush  in  1  kill the incoming instruction.
- rf_we  out  1  register file write enable.
- rf_rd  out  5  register file write address.
- rf_wd  out  DATA_WIDTH  register file write data.
- fwd_valid  out  1  fwd_rd/fwd_data usable for forwarding.
- fwd_rd  out  5  forwarded destination.
- fwd_data  out  DATA_WIDTH  forwarded value.
- wb_exc  out  1  one-cycle pulse: misaligned or illegal load.
- retire_cnt  out  CNT_WIDTH  count of retired instructions.

Behaviour:
- **Reset (async, rst=1).** valid_q=0, fresh_q=0, rd_q=0, wd_q=0, regwrite_q=0, exc_q=0, retire_cnt=0. All outputs therefore read 0.
- **Capture priority at posedge clk.** flush > stall > load.
  - flush: valid_q=0, fresh_q=0.
  - stall (no flush): all state held; fresh_q cleared.
  - otherwise: valid_q=mem_valid, fresh_q=mem_valid, rd_q, regwrite_q, wd_q, exc_q loaded.
- **Writeback data.** Formed combinationally before the register, so rf_wd comes straight from a flop.
- **Load extraction.**
  - Byte lane = mem_addr_lo*8.
  - Halfword lane = mem_addr_lo[1]*16.
  - LB (000) and LH (001) sign-extend.
  - LBU (100) and LHU (101) zero-extend.
  - LW (010) takes the full word.
- **Load exception (exc).** Set when wbsel=01 and any of the following:
  - funct3 is 011, 110 or 111;
  - LH/LHU with addr_lo[0]=1;
  - LW with addr_lo != 00.
  In that case wd is don't-care.
- **Non-load instructions.** exc=0; mem_funct3 and mem_addr_lo are ignored.
- **Latency.** Inputs sampled at posedge N. rf_* valid through cycle N; the register file writes at the following negedge. Decode reads in the second half of the cycle see the new value, so no WB→ID bypass is needed.
- **rf_we** = valid_q & fresh_q & regwrite_q & (rd_q != 0) & !exc_q.
  - Exactly one write per instruction, even if stall holds the entry for several cycles.
  - rf_rd=rd_q and rf_wd=wd_q are driven regardless of rf_we.
- **Forwarding.**
  - fwd_valid = valid_q & regwrite_q & (rd_q != 0) & !exc_q. Uses valid, not fresh, so it stays asserted while held.
  - fwd_rd=rd_q, fwd_data=wd_q.
- **wb_exc** = valid_q & fresh_q & exc_q: one cycle only, and no register write.
- **retire_cnt** increments by 1 at posedge when valid_q & fresh_q & !exc_q. It wraps modulo 2^CNT_WIDTH. Instructions that do not write a register (regwrite_q=0, or rd=x0) still retire.
- **Boundary cases.**
  - stall and flush together: flush wins.
  - rst mid-stall: everything clears immediately, with no write or retire.
  - rd=x0 with regwrite: no write, still retires, not forwarded.

Decomposition:
- Shared package/header holds:
  - WBSEL_ALU/LOAD/PC4/IMM encodings;
  - funct3 load codes F3_LB/LH/LW/LBU/LHU;
  - REG_ZERO=5'd0.
- One sub-module, load_align: combinational extraction, extension and misalignment detect. Inputs funct3, addr_lo, word; outputs data, bad.

Test Plan:
1. ALU write: mem_valid=1, regwrite=1, rd=5, wbsel=00, alu=0x1234 → next cycle rf_we=1, rf_rd=5, rf_wd=0x00001234; retire_cnt 0→1.
2. Load extension: word=0x80FF7F01. LB addr 1 → 0x0000007F; LB addr 3 → 0xFFFFFF80; LHU addr 2 → 0x000080FF; LH addr 2 → 0xFFFF80FF.
3. Misaligned: LW addr 2, rd=7 → wb_exc=1 for exactly one cycle, rf_we=0, fwd_valid=0, retire_cnt unchanged.
4. Stall hold: capture rd=3 value 0xA, then stall 3 cycles → rf_we high only in the first cycle, fwd_valid high all 4 cycles, retire_cnt +1 only.
5. Priority: flush=1 with stall=1 and a valid input → valid_q=0, no write, no retire. rd=0 with regwrite=1 → rf_we=0, retire +1.
6. Async reset: assert rst mid-cycle while a write is pending → rf_we, retire_cnt and fwd_valid drop to 0 immediately. Counter wrap check: with CNT_WIDTH=4, the 16th retire reads 0.
